// File: rtl/truth_table_sweep_checker_if.sv
// Bundle of stimulus/response and status signals between the sweep checker
// and the gate-level block (plus whoever reads the results).
interface truth_table_sweep_checker_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic [N_IN-1:0] stim;
  logic            dut_o;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail_vec;

  // Checker side: drives stimulus and status, receives start and DUT output.
  modport master (
    input  start, dut_o,
    output stim, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

  // Controller/DUT side: requests sweeps, supplies the DUT output.
  modport slave (
    output start, dut_o,
    input  stim, busy, done, pass, err_count, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/truth_table_sweep_checker.sv
// Exhaustive truth-table checker: on start, walks every input vector in
// ascending order, waits SETTLE cycles per vector, then compares the sampled
// DUT output against EXP_TT and accumulates error count / first failing vector.
module truth_table_sweep_checker #(
  parameter int                       N_IN   = 3,
  parameter int                       SETTLE = 1,
  parameter logic [(2**N_IN)-1:0]     EXP_TT = '0
) (
  input logic                        clk,
  input logic                        rst,
  truth_table_sweep_checker_if.master bus
);

  localparam int              NVEC     = 2 ** N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(NVEC);
  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      wait_q, wait_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] ffv_q, ffv_d;

  // Error counter increment that sticks at the number of vectors.
  function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
    if (v == ERR_MAX) return v;
    return v + 1'b1;
  endfunction

  // State and result registers; reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
    end
  end

  // Next-state: accept start outside RUN, otherwise settle / sample / advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          wait_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffv_d   = '0;
        end
      end
      RUN: begin
        if (wait_q != SETTLE_W) begin
          wait_d = wait_q + 4'd1;
        end else begin
          if (bus.dut_o != EXP_TT[idx_q]) begin
            err_d = sat_inc(err_q);
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffv_d = idx_q;
            end
          end
          // Final vector is all-ones, so idx never wraps.
          if (idx_q == LAST_VEC) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            wait_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registered state; stim holds the last vector in DONE.
  assign bus.stim           = idx_q;
  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = (state_q == DONE) && (err_q == '0);
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_truth_table_sweep_checker.sv
// Directed bench: instance A uses the default parameters, instance B uses
// SETTLE=0 with EXP_TT=8'h55. DUT outputs are sampled 1 time unit after the edge.
module tb_truth_table_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   mode_a = 0;

  always #5 clk = ~clk;

  truth_table_sweep_checker_if #(.N_IN(3)) ifa ();
  truth_table_sweep_checker_if #(.N_IN(3)) ifb ();

  truth_table_sweep_checker #(.N_IN(3), .SETTLE(1), .EXP_TT(8'h00)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  truth_table_sweep_checker #(.N_IN(3), .SETTLE(0), .EXP_TT(8'h55)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  // Gate-level blocks under test, a = stim[2], b = stim[1], c = stim[0].
  always_comb begin
    logic a, b, c;
    a = ifa.stim[2];
    b = ifa.stim[1];
    c = ifa.stim[0];
    case (mode_a)
      0:       ifa.dut_o = ((~a & b) | (a & b & ~c)) & (a & c);
      1:       ifa.dut_o = a & c;
      default: ifa.dut_o = 1'b1;
    endcase
  end
  assign ifb.dut_o = ~ifb.stim[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a sweep on A; verify vector stepping and that done rises at cycle 17.
  task automatic sweep_a(input int mode, input logic hold_start);
    mode_a = mode;
    ifa.start = 1'b1;
    tick();
    ifa.start = hold_start;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("stim_c%0d", c), 32'(ifa.stim), 32'((c - 1) / 2));
      chk($sformatf("busy_c%0d", c), 32'(ifa.busy), 32'd1);
      chk($sformatf("done_c%0d", c), 32'(ifa.done), 32'd0);
      tick();
    end
    chk("done_c17", 32'(ifa.done), 32'd1);
    chk("busy_c17", 32'(ifa.busy), 32'd0);
    chk("stim_hold", 32'(ifa.stim), 32'd7);
  endtask

  task automatic results_a(input string t, input int ec, input int fv, input int ffv, input int ps);
    chk({t, "_err"},  32'(ifa.err_count),      32'(ec));
    chk({t, "_fv"},   32'(ifa.fail_valid),     32'(fv));
    chk({t, "_ffv"},  32'(ifa.first_fail_vec), 32'(ffv));
    chk({t, "_pass"}, 32'(ifa.pass),           32'(ps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_stim", 32'(ifa.stim), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    results_a("rst", 0, 0, 0, 0);

    // 1: constant-0 expression matches all-zero table
    sweep_a(0, 1'b0);
    results_a("t1", 0, 0, 0, 1);
    tick();
    tick();
    results_a("t1_stable", 0, 0, 0, 1);

    // 2: a&c mismatches at vectors 5 and 7
    sweep_a(1, 1'b0);
    results_a("t2", 2, 1, 5, 0);

    // 3: SETTLE=0 instance, one cycle per vector, done at cycle 9
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("b_stim_c%0d", c), 32'(ifb.stim), 32'(c - 1));
      chk($sformatf("b_done_c%0d", c), 32'(ifb.done), 32'd0);
      tick();
    end
    chk("b_done_c9", 32'(ifb.done), 32'd1);
    chk("b_pass",    32'(ifb.pass), 32'd1);
    chk("b_err",     32'(ifb.err_count), 32'd0);

    // 4: start held through RUN gives one sweep; start in DONE restarts
    sweep_a(1, 1'b1);
    results_a("t4a", 2, 1, 5, 0);
    mode_a = 0;
    tick();
    ifa.start = 1'b0;
    chk("t4_done_drop", 32'(ifa.done), 32'd0);
    chk("t4_busy",      32'(ifa.busy), 32'd1);
    chk("t4_stim0",     32'(ifa.stim), 32'd0);
    results_a("t4_clr", 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_done_early", 32'(ifa.done), 32'd0);
    tick();
    chk("t4_done2", 32'(ifa.done), 32'd1);
    results_a("t4b", 0, 0, 0, 1);

    // 5: reset mid-sweep while stim=4
    mode_a = 1;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_stim4", 32'(ifa.stim), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_stim", 32'(ifa.stim), 32'd0);
    chk("t5_busy", 32'(ifa.busy), 32'd0);
    chk("t5_done", 32'(ifa.done), 32'd0);
    results_a("t5_rst", 0, 0, 0, 0);
    tick();
    chk("t5_idle", 32'(ifa.busy), 32'd0);
    sweep_a(1, 1'b0);
    results_a("t5", 2, 1, 5, 0);

    // 6: output stuck at 1 -> every vector fails, count reaches 8
    sweep_a(2, 1'b0);
    results_a("t6", 8, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
